// File: rtl/coretest_bus_pkg.sv
// rtl/coretest_bus_pkg.sv - shared types and constants for the coretest bus mux
package coretest_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int PREFIX_W = 8;

    localparam logic [DATA_W-1:0]     UNMAPPED_RDATA      = 32'h0000_0000;
    localparam logic [4*PREFIX_W-1:0] DEFAULT_PREFIX_LIST = {8'h30, 8'h20, 8'h10, 8'h00};

endpackage

// File: rtl/coretest_bus_decode.sv
// rtl/coretest_bus_decode.sv - address prefix to one-hot slave select, lowest index wins
module coretest_bus_decode
    import coretest_bus_pkg::*;
#(
    parameter int                           NUM_SLAVES  = 4,
    parameter logic [PREFIX_W*NUM_SLAVES-1:0] PREFIX_LIST = DEFAULT_PREFIX_LIST
) (
    input  logic [PREFIX_W-1:0]   i_prefix,
    output logic [NUM_SLAVES-1:0] o_sel,
    output logic                  o_hit
);

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        o_sel = '0;
        o_hit = 1'b0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (i_prefix == PREFIX_LIST[k*PREFIX_W +: PREFIX_W]) begin
                o_sel    = '0;
                o_sel[k] = 1'b1;
                o_hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coretest_bus_mux.sv
// rtl/coretest_bus_mux.sv - registered coretest master-to-slaves decoder/mux; optional ACCESS_COUNT_EN counters
module coretest_bus_mux
    import coretest_bus_pkg::*;
#(
    parameter int                             NUM_SLAVES   = 4,
    parameter logic [PREFIX_W*NUM_SLAVES-1:0] PREFIX_LIST  = DEFAULT_PREFIX_LIST,
    parameter logic [PREFIX_W-1:0]            STATS_PREFIX = 8'hFF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         m_cs,
    input  logic                         m_we,
    input  logic [ADDR_W-1:0]            m_address,
    input  logic [DATA_W-1:0]            m_write_data,
    output logic [DATA_W-1:0]            m_read_data,
    output logic                         m_error,
    output logic                         m_ack,
    output logic                         m_busy,
    output logic [NUM_SLAVES-1:0]        s_cs,
    output logic                         s_we,
    output logic [7:0]                   s_address,
    output logic [DATA_W-1:0]            s_write_data,
    input  logic [DATA_W*NUM_SLAVES-1:0] s_read_data,
    input  logic [NUM_SLAVES-1:0]        s_error
);

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_we;
    logic [7:0]              r_addr;
    logic [DATA_W-1:0]       r_wdata;
    logic [NUM_SLAVES-1:0]   r_sel;
    logic                    r_hit;
    logic [DATA_W-1:0]       r_rdata;
    logic                    r_err;
    logic [NUM_SLAVES-1:0]   w_sel;
    logic                    w_hit;
    logic                    w_accept;
    logic                    w_is_stats;
    logic [DATA_W-1:0]       w_mux_rdata;
    logic                    w_mux_err;
    logic [DATA_W-1:0]       w_resp_rdata;
    logic                    w_resp_err;

    coretest_bus_decode #(
        .NUM_SLAVES  (NUM_SLAVES),
        .PREFIX_LIST (PREFIX_LIST)
    ) u_decode (
        .i_prefix (m_address[15:8]),
        .o_sel    (w_sel),
        .o_hit    (w_hit)
    );

    assign w_accept = (r_state == ST_IDLE) && m_cs;

`ifdef ACCESS_COUNT_EN
    logic              r_stats;
    logic [DATA_W-1:0] r_count [NUM_SLAVES];

    assign w_is_stats = (m_address[15:8] == STATS_PREFIX);
`else
    logic w_unused_stats;

    assign w_is_stats     = 1'b0;
    assign w_unused_stats = ^STATS_PREFIX;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (m_cs) w_next_state = ST_ISSUE;
            ST_ISSUE: w_next_state = ST_RESP;
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_sel   <= '0;
            r_hit   <= 1'b0;
`ifdef ACCESS_COUNT_EN
            r_stats <= 1'b0;
`endif
        end else if (w_accept) begin
            r_we    <= m_we;
            r_addr  <= m_address[7:0];
            r_wdata <= m_write_data;
            // The stats window never reaches a slave, even if a slave shares its prefix.
            r_sel   <= w_is_stats ? '0 : w_sel;
            r_hit   <= w_hit && !w_is_stats;
`ifdef ACCESS_COUNT_EN
            r_stats <= w_is_stats;
`endif
        end
    end

    always_comb begin
        w_mux_rdata = '0;
        w_mux_err   = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (r_sel[k]) begin
                w_mux_rdata = w_mux_rdata | s_read_data[k*DATA_W +: DATA_W];
                w_mux_err   = w_mux_err | s_error[k];
            end
        end
    end

    always_comb begin
        w_resp_rdata = UNMAPPED_RDATA;
        w_resp_err   = 1'b1;
        if (r_hit) begin
            w_resp_rdata = r_we ? '0 : w_mux_rdata;
            w_resp_err   = w_mux_err;
        end
`ifdef ACCESS_COUNT_EN
        if (r_stats) begin
            w_resp_rdata = '0;
            w_resp_err   = !r_we;
            if (!r_we) begin
                for (int k = 0; k < NUM_SLAVES; k++) begin
                    if (r_addr == 8'(k)) begin
                        w_resp_rdata = r_count[k];
                        w_resp_err   = 1'b0;
                    end
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (r_state == ST_ISSUE) begin
            r_rdata <= w_resp_rdata;
            r_err   <= w_resp_err;
        end else if (r_state == ST_RESP) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end
    end

`ifdef ACCESS_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_SLAVES; k++) r_count[k] <= '0;
        end else if (r_state == ST_ISSUE) begin
            for (int k = 0; k < NUM_SLAVES; k++) begin
                if (r_stats && r_we) begin
                    r_count[k] <= '0;
                end else if (r_sel[k] && (r_count[k] != 32'hFFFF_FFFF)) begin
                    r_count[k] <= r_count[k] + 32'd1;
                end
            end
        end
    end
`endif

    assign s_cs         = (r_state == ST_ISSUE) ? r_sel : '0;
    assign s_we         = r_we;
    assign s_address    = r_addr;
    assign s_write_data = r_wdata;
    assign m_read_data  = r_rdata;
    assign m_error      = r_err;
    assign m_ack        = (r_state == ST_RESP);
    assign m_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_coretest_bus_mux.sv
// tb/tb_coretest_bus_mux.sv - scoreboard bench for coretest_bus_mux
module tb_coretest_bus_mux;

    logic         clk;
    logic         reset_n;
    logic         m_cs;
    logic         m_we;
    logic [15:0]  m_address;
    logic [31:0]  m_write_data;
    logic [31:0]  m_read_data;
    logic         m_error;
    logic         m_ack;
    logic         m_busy;
    logic [3:0]   s_cs;
    logic         s_we;
    logic [7:0]   s_address;
    logic [31:0]  s_write_data;
    logic [127:0] s_read_data;
    logic [3:0]   s_error;

    logic [31:0]  slv_data [4];
    logic [3:0]   slv_err;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t exp_q [$];
    int    n_cmp;
    int    n_err;

    coretest_bus_mux dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .m_cs         (m_cs),
        .m_we         (m_we),
        .m_address    (m_address),
        .m_write_data (m_write_data),
        .m_read_data  (m_read_data),
        .m_error      (m_error),
        .m_ack        (m_ack),
        .m_busy       (m_busy),
        .s_cs         (s_cs),
        .s_we         (s_we),
        .s_address    (s_address),
        .s_write_data (s_write_data),
        .s_read_data  (s_read_data),
        .s_error      (s_error)
    );

    assign s_read_data = {slv_data[3], slv_data[2], slv_data[1], slv_data[0]};
    assign s_error     = slv_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary / required summary");
        $fatal(1);
    end

    task automatic issue(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                         input logic [31:0] erd, input logic eerr);
        resp_t e;
        @(negedge clk);
        m_cs         = 1'b1;
        m_we         = we;
        m_address    = addr;
        m_write_data = wd;
        e.rdata      = erd;
        e.err        = eerr;
        exp_q.push_back(e);
        @(negedge clk);
        m_cs = 1'b0;
    endtask

    task automatic wait_ack(output int cyc);
        cyc = 0;
        while (m_ack !== 1'b1 && cyc < 6) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({m_ack, m_busy, m_error, s_cs, s_we} !== 8'h00) begin
            $display("FAIL reset_ctrl: got %b required 00000000", {m_ack, m_busy, m_error, s_cs, s_we});
            n_err++;
        end
        n_cmp++;
        if ({m_read_data, s_address, s_write_data} !== 72'h0) begin
            $display("FAIL reset_data: got %h required 0", {m_read_data, s_address, s_write_data});
            n_err++;
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (m_busy !== 1'b0 || m_ack !== 1'b0) begin
            $display("FAIL reset_idle: got busy=%b ack=%b required 0 0", m_busy, m_ack);
            n_err++;
        end
    endtask

    task automatic test_read;
        int    cyc;
        resp_t e;
        slv_data[1] = 32'hCAFE_BABE;
        issue(1'b0, 16'h1004, 32'h0, 32'hCAFE_BABE, 1'b0);
        n_cmp++;
        if (s_cs !== 4'b0010) begin
            $display("FAIL read_s_cs: got %b required 0010", s_cs); n_err++;
        end
        n_cmp++;
        if (s_address !== 8'h04 || s_we !== 1'b0) begin
            $display("FAIL read_s_addr: got %h/%b required 04/0", s_address, s_we); n_err++;
        end
        n_cmp++;
        if (m_busy !== 1'b1 || m_ack !== 1'b0) begin
            $display("FAIL read_busy: got busy=%b ack=%b required 1 0", m_busy, m_ack); n_err++;
        end
        wait_ack(cyc);
        n_cmp++;
        if (cyc !== 1) begin
            $display("FAIL read_latency: got %0d required 1 cycle after issue", cyc); n_err++;
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (m_read_data !== e.rdata || m_error !== e.err) begin
            $display("FAIL read_resp: got %h/%b required %h/%b", m_read_data, m_error, e.rdata, e.err); n_err++;
        end
        n_cmp++;
        if (s_cs !== 4'b0000) begin
            $display("FAIL read_s_cs_resp: got %b required 0000", s_cs); n_err++;
        end
        @(negedge clk);
        n_cmp++;
        if (m_ack !== 1'b0 || m_busy !== 1'b0) begin
            $display("FAIL read_ack_pulse: got ack=%b busy=%b required 0 0", m_ack, m_busy); n_err++;
        end
    endtask

    task automatic test_write;
        int    cyc;
        resp_t e;
        slv_data[0] = 32'hDEAD_BEEF;
        issue(1'b1, 16'h0010, 32'h1234_5678, 32'h0, 1'b0);
        n_cmp++;
        if (s_cs !== 4'b0001 || s_we !== 1'b1) begin
            $display("FAIL write_s_cs: got %b/%b required 0001/1", s_cs, s_we); n_err++;
        end
        n_cmp++;
        if (s_write_data !== 32'h1234_5678 || s_address !== 8'h10) begin
            $display("FAIL write_s_data: got %h/%h required 12345678/10", s_write_data, s_address); n_err++;
        end
        wait_ack(cyc);
        n_cmp++;
        if (cyc !== 1) begin
            $display("FAIL write_latency: got %0d required 1", cyc); n_err++;
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (m_read_data !== e.rdata || m_error !== e.err) begin
            $display("FAIL write_resp: got %h/%b required %h/%b", m_read_data, m_error, e.rdata, e.err); n_err++;
        end
        n_cmp++;
        if (s_we !== 1'b1 || s_write_data !== 32'h1234_5678) begin
            $display("FAIL write_hold: got %b/%h required 1/12345678", s_we, s_write_data); n_err++;
        end
    endtask

    task automatic test_unmapped;
        int    cyc;
        resp_t e;
        issue(1'b0, 16'h5000, 32'h0, 32'h0, 1'b1);
        n_cmp++;
        if (s_cs !== 4'b0000) begin
            $display("FAIL unmapped_s_cs: got %b required 0000", s_cs); n_err++;
        end
        wait_ack(cyc);
        n_cmp++;
        if (cyc !== 1 || s_cs !== 4'b0000) begin
            $display("FAIL unmapped_ack: got cyc=%0d s_cs=%b required 1 0000", cyc, s_cs); n_err++;
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (m_read_data !== e.rdata || m_error !== e.err) begin
            $display("FAIL unmapped_resp: got %h/%b required %h/%b", m_read_data, m_error, e.rdata, e.err); n_err++;
        end
    endtask

    task automatic test_slave_error;
        int    cyc;
        resp_t e;
        slv_data[3] = 32'hA5A5_0003;
        slv_err     = 4'b1000;
        issue(1'b0, 16'h3008, 32'h0, 32'hA5A5_0003, 1'b1);
        n_cmp++;
        if (s_cs !== 4'b1000) begin
            $display("FAIL slverr_s_cs: got %b required 1000", s_cs); n_err++;
        end
        wait_ack(cyc);
        e = exp_q.pop_front();
        n_cmp++;
        if (cyc !== 1 || m_read_data !== e.rdata || m_error !== e.err) begin
            $display("FAIL slverr_resp: got %0d/%h/%b required 1/%h/%b", cyc, m_read_data, m_error, e.rdata, e.err);
            n_err++;
        end
        slv_err = 4'b0000;
    endtask

    task automatic test_busy_drop;
        resp_t e;
        int    acks;
        int    stray;
        slv_data[2] = 32'h2222_0001;
        @(negedge clk);
        m_cs = 1'b1; m_we = 1'b0; m_address = 16'h2000; m_write_data = 32'h0;
        e.rdata = 32'h2222_0001; e.err = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        n_cmp++;
        if (m_busy !== 1'b1) begin
            $display("FAIL drop_busy_t1: got %b required 1", m_busy); n_err++;
        end
        m_address = 16'h1000;
        @(negedge clk);
        m_cs = 1'b0;
        n_cmp++;
        if (m_busy !== 1'b1 || m_ack !== 1'b1) begin
            $display("FAIL drop_busy_t2: got busy=%b ack=%b required 1 1", m_busy, m_ack); n_err++;
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (m_read_data !== e.rdata || m_error !== e.err) begin
            $display("FAIL drop_resp: got %h/%b required %h/%b", m_read_data, m_error, e.rdata, e.err); n_err++;
        end
        acks  = 0;
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (m_ack === 1'b1) acks++;
            if (s_cs !== 4'b0000) stray++;
        end
        n_cmp++;
        if (acks !== 0 || stray !== 0) begin
            $display("FAIL drop_second: got acks=%0d s_cs_pulses=%0d required 0 0", acks, stray); n_err++;
        end
    endtask

    task automatic test_reset_mid;
        int    cyc;
        int    acks;
        resp_t e;
        issue(1'b1, 16'h1020, 32'h55AA_33CC, 32'h0, 1'b0);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({m_ack, m_busy, m_error, s_cs, s_we} !== 8'h00) begin
            $display("FAIL midreset_ctrl: got %b required 00000000", {m_ack, m_busy, m_error, s_cs, s_we}); n_err++;
        end
        n_cmp++;
        if ({m_read_data, s_address, s_write_data} !== 72'h0) begin
            $display("FAIL midreset_data: got %h required 0", {m_read_data, s_address, s_write_data}); n_err++;
        end
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (m_ack === 1'b1) acks++;
        end
        n_cmp++;
        if (acks !== 0) begin
            $display("FAIL midreset_noack: got %0d acks required 0", acks); n_err++;
        end
        slv_data[2] = 32'h0BAD_F00D;
        issue(1'b0, 16'h2000, 32'h0, 32'h0BAD_F00D, 1'b0);
        wait_ack(cyc);
        e = exp_q.pop_front();
        n_cmp++;
        if (cyc !== 1 || m_read_data !== e.rdata || m_error !== e.err) begin
            $display("FAIL midreset_next: got %0d/%h/%b required 1/%h/%b", cyc, m_read_data, m_error, e.rdata, e.err);
            n_err++;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] prefixes [4];
        int         cyc;
        resp_t      e;
        prefixes[0] = 8'h00; prefixes[1] = 8'h10; prefixes[2] = 8'h20; prefixes[3] = 8'h30;
        for (int i = 0; i < 10; i++) begin
            int          k;
            logic        we;
            logic [31:0] wd;
            logic [7:0]  la;
            logic [3:0]  oh;
            k  = $urandom_range(0, 3);
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            la = 8'($urandom_range(0, 255));
            oh = 4'b0001 << k;
            slv_data[k] = $urandom;
            issue(we, {prefixes[k], la}, wd, we ? 32'h0 : slv_data[k], 1'b0);
            n_cmp++;
            if (s_cs !== oh || s_address !== la || s_we !== we) begin
                $display("FAIL b2b_req[%0d]: got %b/%h/%b required %b/%h/%b", i, s_cs, s_address, s_we, oh, la, we);
                n_err++;
            end
            wait_ack(cyc);
            e = exp_q.pop_front();
            n_cmp++;
            if (cyc !== 1 || m_read_data !== e.rdata || m_error !== e.err) begin
                $display("FAIL b2b_resp[%0d]: got %0d/%h/%b required 1/%h/%b", i, cyc, m_read_data, m_error, e.rdata, e.err);
                n_err++;
            end
        end
    endtask

`ifdef ACCESS_COUNT_EN
    task automatic test_stats;
        int    cyc;
        resp_t e;
        logic [15:0] addrs [7];
        logic        wes   [7];
        addrs[0] = 16'hFF00; wes[0] = 1'b1;
        addrs[1] = 16'h2001; wes[1] = 1'b0;
        addrs[2] = 16'h2002; wes[2] = 1'b1;
        addrs[3] = 16'h2003; wes[3] = 1'b0;
        addrs[4] = 16'hFF02; wes[4] = 1'b0;
        addrs[5] = 16'hFF00; wes[5] = 1'b1;
        addrs[6] = 16'hFF02; wes[6] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            logic [31:0] er;
            er = 32'h0;
            if (addrs[i][15:8] == 8'h20 && !wes[i]) er = slv_data[2];
            if (i == 4) er = 32'd3;
            issue(wes[i], addrs[i], 32'h0, er, 1'b0);
            wait_ack(cyc);
            e = exp_q.pop_front();
            n_cmp++;
            if (cyc !== 1 || m_read_data !== e.rdata || m_error !== e.err) begin
                $display("FAIL stats[%0d]: got %0d/%h/%b required 1/%h/%b", i, cyc, m_read_data, m_error, e.rdata, e.err);
                n_err++;
            end
        end
        issue(1'b0, 16'hFF07, 32'h0, 32'h0, 1'b1);
        n_cmp++;
        if (s_cs !== 4'b0000) begin
            $display("FAIL stats_s_cs: got %b required 0000", s_cs); n_err++;
        end
        wait_ack(cyc);
        e = exp_q.pop_front();
        n_cmp++;
        if (m_read_data !== e.rdata || m_error !== e.err) begin
            $display("FAIL stats_oob: got %h/%b required %h/%b", m_read_data, m_error, e.rdata, e.err); n_err++;
        end
    endtask
`endif

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        reset_n      = 1'b0;
        m_cs         = 1'b0;
        m_we         = 1'b0;
        m_address    = 16'h0;
        m_write_data = 32'h0;
        slv_err      = 4'b0000;
        for (int k = 0; k < 4; k++) slv_data[k] = 32'h0;

        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_slave_error();
        test_busy_drop();
        test_reset_mid();
        test_back_to_back();
`ifdef ACCESS_COUNT_EN
        test_stats();
`endif
        n_cmp++;
        if (exp_q.size() !== 0) begin
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size()); n_err++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
